res_stream_sequencer: RTL and testbench
=======================================

// Module: res_stream_sequencer
// PURPOSE
//  Sequences readout of the RES result RAM onto the AXI4-Stream master port once Inference reports done.
//  Issues synchronous RAM reads, buffers results in a 2-entry output FIFO and honours M_AXIS_TREADY
//  backpressure without dropping, duplicating or reordering words.
//  Sits between RES_RAM's read port and M_AXIS in the coprocessor top; the top FSM only pulses start and waits for done.
// PARAMETERS
//  WIDTH       8   RES RAM word width (bits)
//  DEPTH_BITS  6   RES RAM address width
//  NUM_WORDS   64  words per packet; 1..2**DEPTH_BITS
//  AXIS_WIDTH  32  M_AXIS_TDATA width; >= WIDTH
// PORTS
//  ACLK           in   1           clock
//  ARESETN        in   1           synchronous reset, active low
//  start          in   1           one-cycle pulse: begin streaming a packet
//  busy           out  1           high from the cycle after accepted start until done
//  done           out  1           one-cycle pulse after the TLAST handshake
//  ram_rd_en      out  1           RES RAM read enable
//  ram_rd_addr    out  DEPTH_BITS  RES RAM read address
//  ram_rd_data    in   WIDTH       RES RAM data, valid the cycle after ram_rd_en
//  M_AXIS_TVALID  out  1           output word valid
//  M_AXIS_TDATA   out  AXIS_WIDTH  {zeros, WIDTH-bit result}
//  M_AXIS_TLAST   out  1           high on word NUM_WORDS-1 only
//  M_AXIS_TREADY  in   1           downstream ready
// BEHAVIOUR
//  - Reset: ARESETN=0 at any edge -> state IDLE; busy, done, ram_rd_en, TVALID, TLAST = 0; TDATA = 0;
//    counters 0; FIFO and in-flight flag cleared. Mid-packet reset discards the partial packet; no TLAST follows.
//  - States: IDLE -> (start) STREAM -> (last read issued) DRAIN -> (TLAST handshake) IDLE.
//    start outside IDLE is ignored.
//  - Issue rule (STREAM): ram_rd_en=1 when fifo_count + inflight - pop < 2,
//    where pop = TVALID & TREADY. ram_rd_addr = issue counter, 0..NUM_WORDS-1. Counter increments per read.
//  - Any ram_rd_en pulse sets inflight for the next cycle; that cycle ram_rd_data is pushed into the FIFO.
//    The FIFO can never overflow; a push and a pop in the same cycle are both performed.
//  - Latency: start at edge N -> first read (addr 0) in cycle N+1 -> FIFO write at end of N+2 -> TVALID=1 in N+3.
//  - Throughput: 1 word/cycle with TREADY=1 throughout; the TLAST beat is in cycle N+66 for NUM_WORDS=64.
//  - AXIS: TVALID = FIFO non-empty. TVALID never depends combinationally on TREADY.
//    While TVALID=1 and TREADY=0, TDATA/TLAST are held stable. TDATA is the FIFO head, zero-extended.
//  - TLAST: tracked by an output beat counter; asserted with the beat whose counter = NUM_WORDS-1.
//  - done: pulses in the cycle after the TLAST handshake; busy falls in the same cycle. The block is in IDLE then.
//    The first cycle in which a new start is accepted is the cycle of the done pulse.
//  - NUM_WORDS=1: a single beat carrying TLAST=1.
// STRUCTURE
//  - Shared package coproc_pkg: RES_WIDTH, RES_DEPTH_BITS, NUM_RES_WORDS, AXIS_DATA_WIDTH, sequencer state enum.
//  - Sub-module axis_fifo2: 2-entry register FIFO with push, pop, head, count.
//    Holds {last, data}; simultaneous push/pop allowed; synchronous active-low reset.
//  - Top-level: FSM, issue counter, beat counter, inflight flag, done/busy registers.
// TESTING
//  1. RAM preloaded RES[i]=i+1, TREADY=1, start pulse
//     -> 64 beats with TDATA 0x01..0x40 in consecutive cycles, TVALID first in N+3.
//     -> TLAST only on 0x40; done one cycle later.
//  2. TREADY toggled 1,0,1,0 plus random 30% low
//     -> exactly 64 beats in order 0x01..0x40; TDATA/TLAST stable on every stalled cycle.
//  3. TREADY held low 20 cycles at beat 10
//     -> ram_rd_en stops after the FIFO holds 2 words. Resume yields 0x0B,0x0C,... with no gaps or duplicates.
//  4. ARESETN low for 1 cycle at beat 30, then a new start
//     -> all outputs 0 after reset; the new packet restarts at 0x01 and contains 64 beats.
//  5. start re-pulsed mid-packet and together with done
//     -> mid-packet pulse ignored (one 64-beat packet); pulse in the done cycle starts a second packet.
//  6. NUM_WORDS=1 build
//     -> single beat TDATA=0x01 with TLAST=1, done the following cycle.

Source files
------------

// File: rtl/coproc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | coproc_pkg: shared coprocessor sizes and sequencer state encoding |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package coproc_pkg;

  localparam int RES_WIDTH       = 8;
  localparam int RES_DEPTH_BITS  = 6;
  localparam int NUM_RES_WORDS   = 64;
  localparam int AXIS_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_STREAM = 2'd1,
    SEQ_DRAIN  = 2'd2
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/axis_fifo2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axis_fifo2: 2-entry register FIFO, simultaneous push/pop allowed |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module axis_fifo2 #(
  parameter int W = 9
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   cnt_q, cnt_d;

  // Entry 0 is always the head; pop never occurs on an empty FIFO.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = push_data_i;
        else               ent1_d = push_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = push_data_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o  = ent0_q;
  assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/res_stream_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | res_stream_sequencer: streams the RES result RAM onto M_AXIS     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module res_stream_sequencer
  import coproc_pkg::*;
#(
  parameter int WIDTH      = RES_WIDTH,
  parameter int DEPTH_BITS = RES_DEPTH_BITS,
  parameter int NUM_WORDS  = NUM_RES_WORDS,
  parameter int AXIS_WIDTH = AXIS_DATA_WIDTH
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_rd_en,
  output logic [DEPTH_BITS-1:0] ram_rd_addr,
  input  logic [WIDTH-1:0]      ram_rd_data,
  output logic                  M_AXIS_TVALID,
  output logic [AXIS_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY
);

  localparam logic [DEPTH_BITS-1:0] LAST_IDX = DEPTH_BITS'(NUM_WORDS - 1);

  seq_state_e            state_q, state_d;
  logic [DEPTH_BITS-1:0] issue_q, issue_d;
  logic [DEPTH_BITS-1:0] beat_q, beat_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  inflight_q;
  logic                  inflight_last_q;

  logic                  w_pop;
  logic                  w_rd_en;
  logic                  w_issue_last;
  logic [WIDTH:0]        w_head;
  logic [1:0]            w_count;
  logic [2:0]            w_occ;

  axis_fifo2 #(
    .W (WIDTH + 1)
  ) u_fifo (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, ram_rd_data}),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .count_o     (w_count)
  );

  assign M_AXIS_TVALID = (w_count != 2'd0);
  assign w_pop         = M_AXIS_TVALID & M_AXIS_TREADY;
  assign M_AXIS_TDATA  = AXIS_WIDTH'(w_head[WIDTH-1:0]);
  assign M_AXIS_TLAST  = M_AXIS_TVALID & (beat_q == LAST_IDX);

  // Words held plus the one arriving next cycle, less the one leaving now.
  assign w_occ        = {1'b0, w_count} + {2'b00, inflight_q} - {2'b00, w_pop};
  assign w_issue_last = (issue_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    beat_d  = beat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    w_rd_en = 1'b0;
    if (w_pop) beat_d = beat_q + 1'b1;
    case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          state_d = SEQ_STREAM;
          issue_d = '0;
          beat_d  = '0;
          busy_d  = 1'b1;
        end
      end
      SEQ_STREAM: begin
        if (w_occ < 3'd2) begin
          w_rd_en = 1'b1;
          issue_d = issue_q + 1'b1;
          if (w_issue_last) state_d = SEQ_DRAIN;
        end
      end
      SEQ_DRAIN: begin
        if (w_pop && w_head[WIDTH]) begin
          state_d = SEQ_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q         <= SEQ_IDLE;
      issue_q         <= '0;
      beat_q          <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      issue_q         <= issue_d;
      beat_q          <= beat_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      inflight_q      <= w_rd_en;
      inflight_last_q <= w_rd_en & w_issue_last;
    end
  end

  assign ram_rd_en   = w_rd_en;
  assign ram_rd_addr = issue_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_res_stream_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_res_stream_sequencer: directed vector bench for the sequencer |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_res_stream_sequencer;

  localparam int W  = 8;
  localparam int DB = 6;
  localparam int NW = 64;
  localparam int AW = 32;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;

  logic          start = 1'b0, tready = 1'b0;
  logic          busy, done, ram_rd_en, tvalid, tlast;
  logic [DB-1:0] ram_rd_addr;
  logic [W-1:0]  ram_rd_data = '0;
  logic [AW-1:0] tdata;

  logic          start1 = 1'b0, tready1 = 1'b0;
  logic          busy1, done1, ram_rd_en1, tvalid1, tlast1;
  logic [DB-1:0] ram_rd_addr1;
  logic [W-1:0]  ram_rd_data1 = '0;
  logic [AW-1:0] tdata1;

  logic [W-1:0]  mem [NW];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         mode;        // 0 ready, 1 toggle+random, 2 stall window
    int         stall_at;
    int         stall_len;
    bit         mid_start;
    bit         start_at_done;
    bit         pre_started;
    bit         check_lat;
    int         exp_beats;
    logic [7:0] exp_last;
  } vec_t;

  vec_t tbl [5];

  res_stream_sequencer #(
    .WIDTH(W), .DEPTH_BITS(DB), .NUM_WORDS(NW), .AXIS_WIDTH(AW)
  ) u_dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .busy(busy), .done(done),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata), .M_AXIS_TLAST(tlast),
    .M_AXIS_TREADY(tready)
  );

  res_stream_sequencer #(
    .WIDTH(W), .DEPTH_BITS(DB), .NUM_WORDS(1), .AXIS_WIDTH(AW)
  ) u_dut1 (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start1), .busy(busy1), .done(done1),
    .ram_rd_en(ram_rd_en1), .ram_rd_addr(ram_rd_addr1), .ram_rd_data(ram_rd_data1),
    .M_AXIS_TVALID(tvalid1), .M_AXIS_TDATA(tdata1), .M_AXIS_TLAST(tlast1),
    .M_AXIS_TREADY(tready1)
  );

  always #5 ACLK = ~ACLK;

  initial for (int i = 0; i < NW; i++) mem[i] = 8'(i + 1);

  always @(posedge ACLK) begin
    if (ram_rd_en)  ram_rd_data  <= mem[ram_rd_addr];
    if (ram_rd_en1) ram_rd_data1 <= mem[ram_rd_addr1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge ACLK); #1; end
  endtask

  // Runs one packet from the cycle of the start pulse to the done pulse.
  task automatic run_packet(input vec_t v);
    int          c = 1, beat = 0, rd = 0, last_hs = -10, stalled = 0;
    bit          pv = 0, pr = 0, pl = 0, seen = 0, fin = 0, hs;
    logic [31:0] pd = '0;
    if (!v.pre_started) start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
    while (!fin && c < 2000) begin
      case (v.mode)
        1: tready = (c <= 12) ? c[0] : ($urandom_range(0, 9) >= 3);
        2: begin
          if (beat == v.stall_at && stalled < v.stall_len) begin
            tready = 1'b0;
            stalled++;
          end else begin
            tready = 1'b1;
          end
        end
        default: tready = 1'b1;
      endcase
      start = v.mid_start && (c == 20);
      #1;
      if (c == 1) chk("busy_after_start", 32'(busy), 32'(1));
      if (pv && !pr) begin
        chk("stall_valid", 32'(tvalid), 32'(1));
        chk("stall_data", tdata, pd);
        chk("stall_last", 32'(tlast), 32'(pl));
      end
      if (v.mode == 2 && stalled > 2 && !tready) chk("stall_no_read", 32'(ram_rd_en), 32'(0));
      if (ram_rd_en) rd++;
      if (tvalid && !seen) begin
        seen = 1;
        if (v.check_lat) chk("first_valid_cycle", 32'(c), 32'(3));
      end
      hs = tvalid && tready;
      if (hs) begin
        chk("beat_data", tdata, 32'(beat + 1));
        chk("beat_last", 32'(tlast), 32'(beat == v.exp_beats - 1));
        if (tlast) chk("tlast_data", tdata, 32'(v.exp_last));
        if (v.mode == 0) chk("beat_cycle", 32'(c), 32'(3 + beat));
        beat++;
        last_hs = c;
      end
      if (done) begin
        chk("done_after_tlast", 32'(c), 32'(last_hs + 1));
        chk("done_busy_low", 32'(busy), 32'(0));
        chk("beat_count", 32'(beat), 32'(v.exp_beats));
        chk("read_count", 32'(rd), 32'(v.exp_beats));
        fin = 1;
        if (v.start_at_done) start = 1'b1;
      end
      pv = tvalid; pr = tready; pd = tdata; pl = tlast;
      if (!fin) begin
        @(posedge ACLK); #1;
        c++;
      end
    end
    if (!fin) chk("packet_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    int n, guard;

    tbl[0] = '{0, 0,  0,  1'b0, 1'b0, 1'b0, 1'b1, 64, 8'h40};
    tbl[1] = '{1, 0,  0,  1'b0, 1'b0, 1'b0, 1'b1, 64, 8'h40};
    tbl[2] = '{2, 10, 20, 1'b0, 1'b0, 1'b0, 1'b1, 64, 8'h40};
    tbl[3] = '{0, 0,  0,  1'b1, 1'b1, 1'b0, 1'b1, 64, 8'h40};
    tbl[4] = '{0, 0,  0,  1'b0, 1'b0, 1'b1, 1'b1, 64, 8'h40};

    repeat (3) @(posedge ACLK);
    #2;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_rd_en", 32'(ram_rd_en), 32'(0));
    chk("rst_tvalid", 32'(tvalid), 32'(0));
    chk("rst_tlast", 32'(tlast), 32'(0));
    chk("rst_tdata", tdata, 32'(0));
    chk("rst1_tvalid", 32'(tvalid1), 32'(0));
    chk("rst1_tdata", tdata1, 32'(0));
    ARESETN = 1'b1;
    @(posedge ACLK); #1;

    for (int i = 0; i < 5; i++) begin
      run_packet(tbl[i]);
      if (!tbl[i].start_at_done) idle(3);
    end

    // Reset while beat 30 (0x1F) is being presented.
    tready = 1'b1;
    start  = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
    n = 0;
    guard = 0;
    while (n < 30 && guard < 200) begin
      #1;
      if (tvalid) n++;
      @(posedge ACLK); #1;
      guard++;
    end
    chk("midrst_beats_before", 32'(n), 32'(30));
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    chk("midrst_rd_en", 32'(ram_rd_en), 32'(0));
    chk("midrst_tvalid", 32'(tvalid), 32'(0));
    chk("midrst_tlast", 32'(tlast), 32'(0));
    chk("midrst_tdata", tdata, 32'(0));
    repeat (5) begin
      #1;
      chk("midrst_quiet_valid", 32'(tvalid), 32'(0));
      chk("midrst_quiet_done", 32'(done), 32'(0));
      @(posedge ACLK); #1;
    end
    run_packet(tbl[0]);
    idle(3);

    // Single-word packet build.
    tready1 = 1'b1;
    start1  = 1'b1;
    @(posedge ACLK); #1;
    start1 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      chk("nw1_rd_en", 32'(ram_rd_en1), 32'(c == 1));
      chk("nw1_tvalid", 32'(tvalid1), 32'(c == 3));
      chk("nw1_tlast", 32'(tlast1), 32'(c == 3));
      if (c == 3) chk("nw1_tdata", tdata1, 32'h01);
      chk("nw1_done", 32'(done1), 32'(c == 4));
      chk("nw1_busy", 32'(busy1), 32'(c < 4));
      @(posedge ACLK); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
